motor_speed_sequencer: RTL and testbench

MOTOR_SPEED_SEQUENCER -- requirements
Module: motor_speed_sequencer

---
 rtl/motor_speed_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_motor_speed_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/motor_speed_sequencer.sv
// Line-following motor sequencer: debounces three line sensors once per PWM frame,
// runs the steering FSM and slews both wheel pulse widths toward per-state targets.
module motor_speed_sequencer #(
    parameter int unsigned FRAME_LEN     = 1000001,
    parameter logic [15:0] FAST          = 16'd40000,
    parameter logic [15:0] SLOW          = 16'd20000,
    parameter logic [15:0] SEARCH_SPD    = 16'd15000,
    parameter logic [15:0] RAMP_STEP     = 16'd2500,
    parameter int unsigned LOST_FRAMES   = 8,
    parameter int unsigned SEARCH_FRAMES = 100
) (
    input  logic        CLOCK50,
    input  logic        RESET_N,
    input  logic        enable,
    input  logic [2:0]  sensors,
    output logic [15:0] speed_left,
    output logic [15:0] speed_right,
    output logic [2:0]  state,
    output logic        frame_tick
);

    localparam int unsigned CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST    = CW'(FRAME_LEN - 1);
    localparam logic [15:0]   LOST_LAST   = 16'(LOST_FRAMES - 1);
    localparam logic [15:0]   SEARCH_LAST = 16'(SEARCH_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FOLLOW = 3'd1,
        S_TURN_L = 3'd2,
        S_TURN_R = 3'd3,
        S_SEARCH = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        D_CENTRE,
        D_LEFT,
        D_RIGHT,
        D_AMBIG,
        D_NONE
    } line_t;

    typedef enum logic {
        SIDE_L = 1'b0,
        SIDE_R = 1'b1
    } side_t;

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_sync_meta;
    logic [2:0]    r_sync;
    logic [2:0]    r_smp;
    logic [2:0]    r_pat;
    state_t        r_state;
    logic [15:0]   r_lost;
    side_t         r_last_dir;
    logic [15:0]   r_speed_l;
    logic [15:0]   r_speed_r;

    logic          w_tick;
    line_t         w_line;
    state_t        w_next_state;
    logic [15:0]   w_next_lost;
    side_t         w_next_last_dir;
    logic [15:0]   w_tgt_l;
    logic [15:0]   w_tgt_r;

    assign w_tick = (r_cnt == CNT_LAST);

    // NOTE: every register sits on the asynchronous reset and uses non-blocking
    // assignment, so reset clears outputs with no clock and all flops update together.
    always_ff @(posedge CLOCK50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge CLOCK50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync_meta <= '0;
            r_sync      <= '0;
        end else begin
            r_sync_meta <= sensors;
            r_sync      <= r_sync_meta;
        end
    end

    // A pattern reaches r_pat only after two consecutive frame samples agree.
    always_ff @(posedge CLOCK50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_smp <= '0;
            r_pat <= '0;
        end else if (w_tick) begin
            r_smp <= r_sync;
            if (r_sync == r_smp) begin
                r_pat <= r_sync;
            end
        end
    end

    always_comb begin
        unique case (r_pat)
            3'b010, 3'b111: w_line = D_CENTRE;
            3'b100, 3'b110: w_line = D_LEFT;
            3'b001, 3'b011: w_line = D_RIGHT;
            3'b101:         w_line = D_AMBIG;
            default:        w_line = D_NONE;
        endcase
    end

    // NOTE: each always_comb output gets a default first so no path leaves it
    // unassigned and infers a latch.
    always_comb begin
        w_next_state    = r_state;
        w_next_lost     = r_lost;
        w_next_last_dir = r_last_dir;

        if (!enable) begin
            w_next_state = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_next_state = S_FOLLOW;
                    w_next_lost  = '0;
                end
                S_FOLLOW, S_TURN_L, S_TURN_R: begin
                    unique case (w_line)
                        D_CENTRE: begin w_next_state = S_FOLLOW; w_next_lost = '0; end
                        D_LEFT:   begin w_next_state = S_TURN_L; w_next_lost = '0; end
                        D_RIGHT:  begin w_next_state = S_TURN_R; w_next_lost = '0; end
                        D_AMBIG:  w_next_lost = '0;
                        default: begin
                            if (r_lost == LOST_LAST) begin
                                w_next_state = S_SEARCH;
                                w_next_lost  = '0;
                            end else begin
                                w_next_lost = r_lost + 16'd1;
                            end
                        end
                    endcase
                end
                S_SEARCH: begin
                    unique case (w_line)
                        D_CENTRE: begin w_next_state = S_FOLLOW; w_next_lost = '0; end
                        D_LEFT:   begin w_next_state = S_TURN_L; w_next_lost = '0; end
                        D_RIGHT:  begin w_next_state = S_TURN_R; w_next_lost = '0; end
                        default: begin
                            if (r_lost == SEARCH_LAST) begin
                                w_next_state = S_HALT;
                                w_next_lost  = '0;
                            end else begin
                                w_next_lost = r_lost + 16'd1;
                            end
                        end
                    endcase
                end
                S_HALT:  w_next_state = S_HALT;
                default: w_next_state = S_IDLE;
            endcase
        end

        if (w_next_state == S_TURN_L) begin
            w_next_last_dir = SIDE_L;
        end else if (w_next_state == S_TURN_R) begin
            w_next_last_dir = SIDE_R;
        end
    end

    always_ff @(posedge CLOCK50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= S_IDLE;
            r_lost     <= '0;
            r_last_dir <= SIDE_L;
        end else if (w_tick) begin
            r_state    <= w_next_state;
            r_lost     <= w_next_lost;
            r_last_dir <= w_next_last_dir;
        end
    end

    // Targets come from the pre-tick state, so speed changes trail the state by a frame.
    always_comb begin
        w_tgt_l = '0;
        w_tgt_r = '0;
        unique case (r_state)
            S_FOLLOW: begin w_tgt_l = FAST; w_tgt_r = FAST; end
            S_TURN_L: begin w_tgt_l = SLOW; w_tgt_r = FAST; end
            S_TURN_R: begin w_tgt_l = FAST; w_tgt_r = SLOW; end
            S_SEARCH: begin
                if (r_last_dir == SIDE_L) begin
                    w_tgt_r = SEARCH_SPD;
                end else begin
                    w_tgt_l = SEARCH_SPD;
                end
            end
            default: ;
        endcase
    end

    function automatic logic [15:0] ramp(input logic [15:0] cur, input logic [15:0] tgt);
        logic [16:0] up;
        logic [16:0] gap;
        up  = {1'b0, cur} + {1'b0, RAMP_STEP};
        gap = {1'b0, cur} - {1'b0, tgt};
        if (cur < tgt) begin
            ramp = (up > {1'b0, tgt}) ? tgt : up[15:0];
        end else if (cur > tgt) begin
            ramp = (gap > {1'b0, RAMP_STEP}) ? (cur - RAMP_STEP) : tgt;
        end else begin
            ramp = cur;
        end
    endfunction

    always_ff @(posedge CLOCK50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_speed_l <= '0;
            r_speed_r <= '0;
        end else if (w_tick) begin
            r_speed_l <= ramp(r_speed_l, w_tgt_l);
            r_speed_r <= ramp(r_speed_r, w_tgt_r);
        end
    end

    assign speed_left  = r_speed_l;
    assign speed_right = r_speed_r;
    assign state       = r_state;
    assign frame_tick  = w_tick;

endmodule

// File: tb/tb_motor_speed_sequencer.sv
// Scoreboard bench for motor_speed_sequencer: stimulus queues the expected post-tick
// state and speeds per frame; a monitor compares them after every frame tick.
module tb_motor_speed_sequencer;

    localparam int FL = 100;

    logic        CLOCK50 = 1'b0;
    logic        RESET_N = 1'b0;
    logic        enable  = 1'b1;
    logic [2:0]  sensors = 3'b010;
    logic [15:0] speed_left;
    logic [15:0] speed_right;
    logic [2:0]  state;
    logic        frame_tick;

    always #5 CLOCK50 = ~CLOCK50;

    motor_speed_sequencer #(
        .FRAME_LEN    (FL),
        .LOST_FRAMES  (3),
        .SEARCH_FRAMES(4)
    ) u_dut (
        .CLOCK50    (CLOCK50),
        .RESET_N    (RESET_N),
        .enable     (enable),
        .sensors    (sensors),
        .speed_left (speed_left),
        .speed_right(speed_right),
        .state      (state),
        .frame_tick (frame_tick)
    );

    typedef struct {
        int          tick_no;
        logic [2:0]  st;
        logic [15:0] l;
        logic [15:0] r;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   frame_no = 0;
    int   last_cycles = 0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: after each tick edge, pop one expectation and compare.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLOCK50);
            if (frame_tick === 1'b1 && RESET_N === 1'b1) begin
                @(posedge CLOCK50);
                #1;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: tick with no expectation, state %0d", state);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("t%0d_state", e.tick_no), 32'(state), 32'(e.st));
                    check($sformatf("t%0d_left", e.tick_no), 32'(speed_left), 32'(e.l));
                    check($sformatf("t%0d_right", e.tick_no), 32'(speed_right), 32'(e.r));
                end
            end
        end
    end

    task automatic wait_tick(output int cycles);
        int n;
        n = 0;
        do begin
            @(negedge CLOCK50);
            n++;
        end while (frame_tick !== 1'b1 && n < 2 * FL);
        if (frame_tick !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: no frame_tick within %0d cycles", 2 * FL);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
        @(posedge CLOCK50);
        #2;
        cycles = n + 1;
    endtask

    task automatic frame(input bit en, input logic [2:0] sens, input int st, input int l, input int r);
        exp_t e;
        int   n;
        enable  = en;
        sensors = sens;
        frame_no++;
        e.tick_no = frame_no;
        e.st      = 3'(st);
        e.l       = 16'(l);
        e.r       = 16'(r);
        sb_q.push_back(e);
        wait_tick(n);
        last_cycles = n;
    endtask

    initial begin : stimulus
        logic [2:0] s;
        repeat (3) @(negedge CLOCK50);
        check("rst_state", 32'(state), 32'd0);
        check("rst_left", 32'(speed_left), 32'd0);
        check("rst_right", 32'(speed_right), 32'd0);
        check("rst_tick", 32'(frame_tick), 32'd0);
        @(negedge CLOCK50);
        #1 RESET_N = 1'b1;

        // Start-up ramp from rest to cruise.
        for (int k = 1; k <= 19; k++) begin
            frame(1'b1, 3'b010, 1, imin(2500 * (k - 1), 40000), imin(2500 * (k - 1), 40000));
            if (k == 1) check("first_tick_cycles", 32'(last_cycles), 32'(FL));
        end

        // Line drifts left: TURN_L, left wheel slows to SLOW.
        for (int k = 20; k <= 31; k++) begin
            frame(1'b1, 3'b100, (k < 22) ? 1 : 2,
                  (k <= 22) ? 40000 : imax(40000 - 2500 * (k - 22), 20000), 40000);
        end

        // Recentre, then lose the line: SEARCH (last_dir L), HALT, disable to IDLE.
        frame(1'b1, 3'b010, 2, 20000, 40000);
        frame(1'b1, 3'b010, 2, 20000, 40000);
        frame(1'b1, 3'b010, 1, 20000, 40000);
        frame(1'b1, 3'b010, 1, 22500, 40000);
        for (int k = 36; k <= 58; k++) begin
            frame((k < 58), 3'b000,
                  (k <= 39) ? 1 : (k <= 43) ? 4 : (k <= 57) ? 5 : 0,
                  (k <= 40) ? 22500 + 2500 * (k - 35) : imax(35000 - 2500 * (k - 40), 0),
                  (k <= 40) ? 40000 : imax(40000 - 2500 * (k - 40), 0));
        end

        // Restart into TURN_R, ambiguous hold, one-frame glitch.
        for (int k = 59; k <= 62; k++) begin
            frame(1'b1, 3'b001, (k <= 60) ? 1 : 3, 2500 * (k - 59), 2500 * (k - 59));
        end
        for (int k = 63; k <= 66; k++) begin
            frame(1'b1, 3'b101, 3, 2500 * (k - 59), 2500 * (k - 59));
        end
        for (int k = 67; k <= 74; k++) begin
            s = (k == 67) ? 3'b010 : (k <= 69) ? 3'b101 : 3'b000;
            frame(1'b1, s, (k <= 73) ? 3 : 4, 2500 * (k - 59), imin(2500 * (k - 59), 20000));
        end

        // SEARCH with last_dir R, recovered by a left pattern on the last search frame.
        for (int k = 75; k <= 77; k++) begin
            s = (k == 75) ? 3'b000 : 3'b110;
            frame(1'b1, s, 4, 37500 - 2500 * (k - 74), 20000 - 2500 * (k - 74));
        end
        for (int k = 78; k <= 86; k++) begin
            frame(1'b1, 3'b110, 2, imax(27500 - 2500 * (k - 78), 20000), 10000 + 2500 * (k - 78));
        end

        // Asynchronous reset mid-frame, between clock edges.
        repeat (40) @(negedge CLOCK50);
        #1 RESET_N = 1'b0;
        #1;
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_left", 32'(speed_left), 32'd0);
        check("async_rst_right", 32'(speed_right), 32'd0);
        check("async_rst_tick", 32'(frame_tick), 32'd0);
        repeat (3) @(negedge CLOCK50);
        check("rst_hold_left", 32'(speed_left), 32'd0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
